// File: rtl/stream_skid_buffer.sv
// -----------------------------------------------------------------------------
// stream_skid_buffer
//
// Full register slice for a valid/ready stream. Both the forward path
// (out_valid/out_data) and the backward path (in_ready) come straight from
// flops, so there is no combinational path from out_ready to in_ready or from
// in_valid/in_data to any output. A main register plus one skid register give
// two words of storage, which is enough to sustain one transfer per cycle.
//
// Handshake semantics (both sides): a word moves on a rising clock edge when
// valid and ready are both 1 in the preceding cycle. A source holding valid
// while ready is 0 is simply not taken and its data is ignored. Once
// out_valid is 1 it stays 1 with out_data unchanged until the word is
// consumed.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst_n        asynchronous active-low reset, discards buffered words
//   in_valid     upstream word valid
//   in_data      upstream data word (WIDTH bits)
//   in_ready     registered; buffer accepts a word this cycle
//   out_valid    registered; buffer presents a word
//   out_data     registered; word at the head of the buffer
//   out_ready    downstream accepts the presented word this cycle
//   occupancy    words held (0, 1 or 2); this is also the FSM state code
//   stall_clr    synchronous clear of stall_count (wins over an increment)
//   stall_count  saturating count of cycles with out_valid=1, out_ready=0
// -----------------------------------------------------------------------------
module stream_skid_buffer #(
    parameter int WIDTH   = 32,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic [1:0]         occupancy,
    input  logic               stall_clr,
    output logic [STALL_W-1:0] stall_count
);

    // State codes equal the number of words held, so the state register is
    // observable directly on the occupancy output.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;
    logic [WIDTH-1:0]   w_main_nxt;
    logic [WIDTH-1:0]   w_skid_nxt;
    logic [STALL_W-1:0] r_stall;

    logic w_accept;
    logic w_consume;
    logic w_stalled;

    // ------------------------------------------------------------------
    // Outputs decoded from registered state only
    // ------------------------------------------------------------------
    assign out_valid   = (r_state != S_EMPTY);
    assign in_ready    = (r_state != S_FULL);
    assign out_data    = r_main;
    assign occupancy   = r_state;
    assign stall_count = r_stall;

    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;
    assign w_stalled = out_valid && !out_ready;

    // ------------------------------------------------------------------
    // FSM state and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath steering
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                    w_main_nxt  = in_data;
                end
            end

            S_BUSY: begin
                if (w_accept && !w_consume) begin
                    // Downstream stalled: park the new word behind main.
                    w_state_nxt = S_FULL;
                    w_skid_nxt  = in_data;
                end else if (!w_accept && w_consume) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_accept && w_consume) begin
                    // Pass-through: head leaves, new word becomes head.
                    w_main_nxt = in_data;
                end
            end

            S_FULL: begin
                // in_ready is 0 here, so no accept can occur.
                if (w_consume) begin
                    w_state_nxt = S_BUSY;
                    w_main_nxt  = r_skid;
                end
            end

            default: begin
                // Unused code: recover to a clean empty buffer.
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stall counter: saturates instead of wrapping, clear wins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (stall_clr) begin
            r_stall <= '0;
        end else if (w_stalled && (r_stall != {STALL_W{1'b1}})) begin
            r_stall <= r_stall + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_stream_skid_buffer
//
// Directed and randomized checks of stream_skid_buffer (WIDTH=32, STALL_W=4).
// Inputs are driven 1 time unit after each rising edge and outputs are sampled
// at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_stream_skid_buffer;

  localparam int WIDTH     = 32;
  localparam int STALL_W   = 4;
  localparam int N_RAND    = 10000;
  localparam int RAND_BUDG = 60000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_ready;
  logic [1:0]         occupancy;
  logic               stall_clr;
  logic [STALL_W-1:0] stall_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stream_skid_buffer #(
    .WIDTH   (WIDTH),
    .STALL_W (STALL_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .occupancy   (occupancy),
    .stall_clr   (stall_clr),
    .stall_count (stall_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks;
  int n_errors;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  32'(in_ready),    32'd1);
    check_eq({tag, "_out_valid"}, 32'(out_valid),   32'd0);
    check_eq({tag, "_out_data"},  32'(out_data),    32'd0);
    check_eq({tag, "_occ"},       32'(occupancy),   32'd0);
    check_eq({tag, "_stall"},     32'(stall_count), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall_clr = 1'b0;

    // Power-on reset
    #2 rst_n = 1'b0;
    step();
    step();
    check_reset_outputs("por");
    rst_n = 1'b1;
    step();

    // -------------------------------------------------------------------------
    // Reset mid-operation
    // -------------------------------------------------------------------------
    out_ready = 1'b0;
    drive_in(1'b1, 32'h11);
    step();
    drive_in(1'b1, 32'h22);
    step();
    drive_in(1'b0, 32'h0);
    check_eq("mid_full_occ",   32'(occupancy), 32'd2);
    check_eq("mid_full_ready", 32'(in_ready),  32'd0);
    check_eq("mid_full_data",  out_data,       32'h11);
    check_eq("mid_full_stall", 32'(stall_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #1 rst_n = 1'b1;
    step();
    check_reset_outputs("post_rst");
    drive_in(1'b1, 32'h33);
    step();
    drive_in(1'b0, 32'h0);
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);
    check_eq("post_rst_data",  out_data,       32'h33);
    out_ready = 1'b1;
    step();
    check_eq("post_rst_drain", 32'(occupancy), 32'd0);

    // -------------------------------------------------------------------------
    // Streaming with out_ready held high: 0x01..0x08 back-to-back
    // -------------------------------------------------------------------------
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive_in(1'b1, WIDTH'(i + 1));
      else       drive_in(1'b0, '0);
      check_eq("stream_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        check_eq("stream_valid", 32'(out_valid), 32'd1);
        check_eq("stream_data",  out_data,       32'(i));
        check_eq("stream_occ",   32'(occupancy), 32'd1);
      end
      step();
    end
    drive_in(1'b0, '0);
    check_eq("stream_end_occ", 32'(occupancy), 32'd0);

    // -------------------------------------------------------------------------
    // Backpressure: 0xA, 0xB fill the buffer, 0xC waits at the source
    // -------------------------------------------------------------------------
    out_ready = 1'b0;
    drive_in(1'b1, 32'hA);
    step();
    drive_in(1'b1, 32'hB);
    step();
    check_eq("bp_occ",   32'(occupancy), 32'd2);
    check_eq("bp_ready", 32'(in_ready),  32'd0);
    check_eq("bp_head",  out_data,       32'hA);
    drive_in(1'b1, 32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_hold_occ",  32'(occupancy), 32'd2);
      check_eq("bp_hold_data", out_data,       32'hA);
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_drain_b",     out_data,       32'hB);
    check_eq("bp_drain_b_rdy", 32'(in_ready),  32'd1);
    step();
    drive_in(1'b0, '0);
    check_eq("bp_drain_c",     out_data,       32'hC);
    check_eq("bp_drain_c_occ", 32'(occupancy), 32'd1);
    step();
    check_eq("bp_empty", 32'(occupancy), 32'd0);

    // -------------------------------------------------------------------------
    // Ignored input while FULL
    // -------------------------------------------------------------------------
    out_ready = 1'b0;
    drive_in(1'b1, 32'h55);
    step();
    drive_in(1'b1, 32'h66);
    step();
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 32'h77 + 32'(i) * 32'h11);
      step();
      check_eq("ign_occ",  32'(occupancy), 32'd2);
      check_eq("ign_head", out_data,       32'h55);
    end
    drive_in(1'b0, '0);
    out_ready = 1'b1;
    check_eq("ign_drain_0", out_data, 32'h55);
    step();
    check_eq("ign_drain_1", out_data, 32'h66);
    check_eq("ign_valid_1", 32'(out_valid), 32'd1);
    step();
    check_eq("ign_empty_valid", 32'(out_valid), 32'd0);
    check_eq("ign_empty_occ",   32'(occupancy), 32'd0);

    // -------------------------------------------------------------------------
    // Stall counter saturation and clear priority (STALL_W=4 -> max 15)
    // -------------------------------------------------------------------------
    out_ready = 1'b0;
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    check_eq("stc_clear_idle", 32'(stall_count), 32'd0);
    drive_in(1'b1, 32'h5A);
    step();
    drive_in(1'b0, '0);
    check_eq("stc_start", 32'(stall_count), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check_eq("stc_count", 32'(stall_count), (i < 15) ? 32'(i) : 32'd15);
    end
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    check_eq("stc_clr_prio", 32'(stall_count), 32'd0);
    step();
    check_eq("stc_resume_1", 32'(stall_count), 32'd1);
    step();
    check_eq("stc_resume_2", 32'(stall_count), 32'd2);
    check_eq("stc_head", out_data, 32'h5A);
    out_ready = 1'b1;
    step();
    check_eq("stc_no_inc_consume", 32'(stall_count), 32'd2);
    step();
    check_eq("stc_no_inc_empty", 32'(stall_count), 32'd2);

    // -------------------------------------------------------------------------
    // Random stress with in-order scoreboard
    // -------------------------------------------------------------------------
    begin
      int   sent;
      int   recv;
      int   cyc;
      logic acc;
      logic cons;
      logic prev_stall;
      logic [WIDTH-1:0] prev_data;

      sent       = 0;
      recv       = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      exp_q.delete();

      while ((recv < N_RAND) && (cyc < RAND_BUDG)) begin
        check_eq("rnd_ready_vs_occ", 32'(in_ready), 32'(occupancy != 2'd2));
        check_eq("rnd_occ_model",    32'(occupancy), 32'(exp_q.size()));
        if (prev_stall) begin
          check_eq("rnd_stall_valid", 32'(out_valid), 32'd1);
          check_eq("rnd_stall_data",  out_data,       prev_data);
        end

        if ((sent < N_RAND) && ($urandom_range(0, 1) == 1))
          drive_in(1'b1, WIDTH'($urandom()));
        else
          drive_in(1'b0, WIDTH'($urandom()));
        out_ready = ($urandom_range(0, 1) == 1);

        acc        = in_valid && in_ready;
        cons       = out_valid && out_ready;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;

        if (cons) begin
          if (exp_q.size() == 0) begin
            check_eq("rnd_unexpected_word", out_data, 32'hDEAD_BEEF);
          end else begin
            check_eq("rnd_data_order", out_data, exp_q[0]);
            void'(exp_q.pop_front());
          end
          recv++;
        end
        if (acc) begin
          exp_q.push_back(in_data);
          sent++;
        end

        step();
        cyc++;
      end
      drive_in(1'b0, '0);
      out_ready = 1'b0;
      check_eq("rnd_budget_ok", 32'(cyc < RAND_BUDG), 32'd1);
      check_eq("rnd_recv_count", 32'(recv), 32'(N_RAND));
      check_eq("rnd_end_occ", 32'(occupancy), 32'd0);
    end

    // -------------------------------------------------------------------------
    // Final report
    // -------------------------------------------------------------------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_skid_buffer.md
Name: stream_skid_buffer

Overview:
- Full register slice for the valid/ready stream protocol used across the datapath.
- Registers both the forward path (out_valid/out_data) and the backward path (in_ready). No combinational path exists from out_ready to in_ready, or from in_valid/in_data to the outputs.
- A two-entry skid (main + skid register) sustains one transfer per cycle.
- Placed wherever a ready-path timing break is required between two pipeline stages; complements the forward-only pipeline register.

Parameters:
- WIDTH, 32, data word width in bits.
- STALL_W, 16, width of the saturating output-stall counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  registered; buffer can accept this cycle.
- out_valid  output  1  registered; buffer presents a word.
- out_data  output  WIDTH  registered; word at head of buffer.
- out_ready  input  1  downstream accepts this cycle.
- occupancy  output  2  words held: 0, 1 or 2.
- stall_clr  input  1  synchronous clear of stall_count.
- stall_count  output  STALL_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Transfers:
  - accept = in_valid && in_ready.
  - consume = out_valid && out_ready.
  - in_valid while in_ready=0 is ignored; in_data is don't-care.
- Reset, asynchronous, rst_n low:
  - state EMPTY, main_reg=0, skid_reg=0, stall_count=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, occupancy=0.
  - Applies immediately, including mid-operation; buffered words are discarded.
- FSM states:
  - EMPTY (occ 0)
  - BUSY (occ 1; main valid)
  - FULL (occ 2; main + skid valid)
- Transitions, per clock:
  - EMPTY: accept -> BUSY, main<=in_data. Otherwise stay.
  - BUSY, accept && !consume -> FULL, skid<=in_data.
  - BUSY, !accept && consume -> EMPTY.
  - BUSY, accept && consume -> BUSY, main<=in_data.
  - BUSY, neither -> stay.
  - FULL, consume -> BUSY, main<=skid. Accept is impossible because in_ready=0. Otherwise stay.
- Outputs are decoded from registered state only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - out_data = main_reg.
  - occupancy = state encoding count.
- Latency and throughput:
  - Word accepted in EMPTY appears at out_valid on the next cycle (1-cycle latency).
  - With out_ready held 1, throughput is 1 word/cycle and in_ready stays 1.
- Ordering: strict FIFO order; no word lost or duplicated under any out_ready pattern.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Stall counter:
  - Each cycle with out_valid && !out_ready, stall_count increments, saturating at 2^STALL_W-1 (no wrap).
  - stall_clr has priority: it sets the counter to 0 even when a stall occurs in the same cycle.

Test Plan:
- Reset mid-operation: fill to FULL with 0x11, 0x22, then assert rst_n=0 asynchronously between edges -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=0, stall_count=0. After release, the first accepted word appears 1 cycle later.
- Streaming: out_ready=1, drive 0x01..0x08 back-to-back -> out_data 0x01..0x08 on consecutive cycles starting 1 cycle after the first accept; in_ready constant 1; occupancy never exceeds 1.
- Backpressure:
  - out_ready=0, send 0xA then 0xB -> occupancy 2 and in_ready=0 the cycle after 0xB is accepted.
  - 0xC held by the source is not taken.
  - Raise out_ready -> outputs 0xA, 0xB, 0xC in order with no gaps beyond one per cycle.
- Random stress: random in_valid and out_ready (50%) over 10k words -> scoreboard matches in order. Assertions hold: no out_valid/out_data change while stalled, and in_ready == (occupancy != 2).
- Stall counter with STALL_W=4:
  - Hold a valid word with out_ready=0 for 20 cycles -> stall_count=15 (saturated).
  - Pulse stall_clr while still stalled -> 0 on that edge, then resumes counting 1, 2, ...
- Ignored input: in FULL, toggle in_data and hold in_valid=1 with out_ready=0 -> stored words unchanged. After draining, only the words accepted while in_ready=1 appear.
